mdu_ctrl: RTL and testbench

MDU_CTRL -- requirements
Module: mdu_ctrl

---
 rtl/mdu_ctrl_pkg.sv | 25 ++
 rtl/mdu_ctrl_md_calc.sv | 57 +++++
 rtl/mdu_ctrl.sv | 115 +++++++++++
 tb/tb_mdu_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_ctrl_pkg.sv
// Shared op encodings, default latencies and FSM state type for the multiply/divide controller.
package mdu_ctrl_pkg;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_e;

    localparam int MULT_CYC_DEFAULT = 5;
    localparam int DIV_CYC_DEFAULT  = 10;

    function automatic int max_int(input int x, input int y);
        return (x > y) ? x : y;
    endfunction

endpackage

// File: rtl/mdu_ctrl_md_calc.sv
// Combinational multiply/divide datapath: produces HI/LO for one op; valid is low for non-arith ops
// and for a divide by zero, which must leave the architectural registers untouched.
module md_calc
    import mdu_ctrl_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  op,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        valid
);

    logic [63:0] prod;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic        is_signed;

    // Signed divide goes through magnitudes so 0x80000000 / -1 wraps cleanly to 0x80000000.
    always_comb begin
        hi        = '0;
        lo        = '0;
        valid     = 1'b0;
        prod      = '0;
        is_signed = (op == OP_MULT) || (op == OP_DIV);
        a_mag     = (is_signed && a[31]) ? (~a + 32'd1) : a;
        b_mag     = (is_signed && b[31]) ? (~b + 32'd1) : b;
        q_mag     = (b_mag != 32'd0) ? (a_mag / b_mag) : 32'd0;
        r_mag     = (b_mag != 32'd0) ? (a_mag % b_mag) : 32'd0;
        case (op)
            OP_MULT: begin
                prod     = {{32{a[31]}}, a} * {{32{b[31]}}, b};
                {hi, lo} = prod;
                valid    = 1'b1;
            end
            OP_MULTU: begin
                prod     = {32'd0, a} * {32'd0, b};
                {hi, lo} = prod;
                valid    = 1'b1;
            end
            OP_DIV: begin
                lo    = (a[31] ^ b[31]) ? (~q_mag + 32'd1) : q_mag;
                hi    = a[31] ? (~r_mag + 32'd1) : r_mag;
                valid = (b != 32'd0);
            end
            OP_DIVU: begin
                lo    = q_mag;
                hi    = r_mag;
                valid = (b != 32'd0);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mdu_ctrl.sv
// Multiply/divide unit controller: fixed-latency busy window, pending HI/LO committed when Busy falls,
// and the D-stage stall request for instructions that touch the MDU.
module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int MULT_CYC = MULT_CYC_DEFAULT,
    parameter int DIV_CYC  = DIV_CYC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start_E,
    input  logic [2:0]  MdOp_E,
    input  logic [31:0] A_E,
    input  logic [31:0] B_E,
    input  logic        MdUse_D,
    output logic        Busy,
    output logic        Stall_D,
    output logic [31:0] Hi,
    output logic [31:0] Lo
);

    localparam int CNT_BITS = $clog2(max_int(MULT_CYC, DIV_CYC) + 1);
    localparam int CNT_W    = (CNT_BITS < 4) ? 4 : CNT_BITS;
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYC);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYC);

    md_state_e        state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [31:0]      hi_reg, hi_next;
    logic [31:0]      lo_reg, lo_next;
    logic [31:0]      pend_hi_reg, pend_hi_next;
    logic [31:0]      pend_lo_reg, pend_lo_next;
    logic             pend_we_reg, pend_we_next;

    logic [31:0] calc_hi;
    logic [31:0] calc_lo;
    logic        calc_valid;

    md_calc u_calc (
        .a     (A_E),
        .b     (B_E),
        .op    (MdOp_E),
        .hi    (calc_hi),
        .lo    (calc_lo),
        .valid (calc_valid)
    );

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        hi_next      = hi_reg;
        lo_next      = lo_reg;
        pend_hi_next = pend_hi_reg;
        pend_lo_next = pend_lo_reg;
        pend_we_next = pend_we_reg;
        case (state_reg)
            ST_IDLE: begin
                if (Start_E) begin
                    case (MdOp_E)
                        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                            state_next   = ST_RUN;
                            cnt_next     = (MdOp_E == OP_MULT || MdOp_E == OP_MULTU) ? MULT_LOAD : DIV_LOAD;
                            pend_hi_next = calc_hi;
                            pend_lo_next = calc_lo;
                            pend_we_next = calc_valid;
                        end
                        OP_MTHI: hi_next = A_E;
                        OP_MTLO: lo_next = A_E;
                        default: ;
                    endcase
                end
            end
            ST_RUN: begin
                // Starts are ignored here; the in-flight op owns the counter and pending registers.
                if (cnt_reg <= CNT_W'(1)) begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                    if (pend_we_reg) begin
                        hi_next = pend_hi_reg;
                        lo_next = pend_lo_reg;
                    end
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= ST_IDLE;
            cnt_reg     <= '0;
            hi_reg      <= '0;
            lo_reg      <= '0;
            pend_hi_reg <= '0;
            pend_lo_reg <= '0;
            pend_we_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            hi_reg      <= hi_next;
            lo_reg      <= lo_next;
            pend_hi_reg <= pend_hi_next;
            pend_lo_reg <= pend_lo_next;
            pend_we_reg <= pend_we_next;
        end
    end

    assign Busy    = (state_reg == ST_RUN);
    assign Stall_D = MdUse_D & (Busy | Start_E);
    assign Hi      = hi_reg;
    assign Lo      = lo_reg;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed vector table, multi-cycle corner sequences and random ops
// compared against a plain-arithmetic model of HI/LO and the busy length.
module tb_mdu_ctrl;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        Start_E;
    logic [2:0]  MdOp_E;
    logic [31:0] A_E;
    logic [31:0] B_E;
    logic        MdUse_D;
    logic        Busy;
    logic        Stall_D;
    logic [31:0] Hi;
    logic [31:0] Lo;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] m_hi;
    logic [31:0] m_lo;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } vec_t;

    vec_t vecs[9];

    mdu_ctrl #(.MULT_CYC(MULT_N), .DIV_CYC(DIV_N)) dut (
        .clk     (clk),
        .reset   (reset),
        .Start_E (Start_E),
        .MdOp_E  (MdOp_E),
        .A_E     (A_E),
        .B_E     (B_E),
        .MdUse_D (MdUse_D),
        .Busy    (Busy),
        .Stall_D (Stall_D),
        .Hi      (Hi),
        .Lo      (Lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference: architectural effect of one op on HI/LO and its busy length.
    task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, output int cyc);
        longint            sa, sb, sq, sr;
        longint unsigned   up;
        cyc = 0;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        case (op)
            3'd0: begin
                sq = sa * sb;
                m_hi = sq[63:32]; m_lo = sq[31:0]; cyc = MULT_N;
            end
            3'd1: begin
                up = longint'(a) * longint'(b);
                m_hi = up[63:32]; m_lo = up[31:0]; cyc = MULT_N;
            end
            3'd2: begin
                cyc = DIV_N;
                if (b != 0) begin
                    sq = sa / sb; sr = sa % sb;
                    m_lo = sq[31:0]; m_hi = sr[31:0];
                end
            end
            3'd3: begin
                cyc = DIV_N;
                if (b != 0) begin
                    m_lo = a / b; m_hi = a % b;
                end
            end
            3'd4: m_hi = a;
            3'd5: m_lo = a;
            default: ;
        endcase
    endtask

    // Issue one start pulse and count the negedges at which Busy is seen high.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, output int busy_cnt);
        @(negedge clk);
        Start_E = 1'b1; MdOp_E = op; A_E = a; B_E = b;
        @(negedge clk);
        Start_E = 1'b0;
        busy_cnt = 0;
        while (Busy && busy_cnt < 50) begin
            busy_cnt++;
            @(negedge clk);
        end
    endtask

    initial begin
        int cyc, exp_cyc, cnt;
        logic [2:0]  rop;
        logic [31:0] ra, rb;

        vecs[0] = '{3'd0, 32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFFA, MULT_N};
        vecs[1] = '{3'd3, 32'd100,       32'd7,         32'd2,         32'd14,        DIV_N};
        vecs[2] = '{3'd2, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_N};
        vecs[3] = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, DIV_N};
        vecs[4] = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, MULT_N};
        vecs[5] = '{3'd4, 32'h0000_1234, 32'd0,         32'h0000_1234, 32'h0000_0001, 0};
        vecs[6] = '{3'd2, 32'd55,        32'd0,         32'h0000_1234, 32'h0000_0001, DIV_N};
        vecs[7] = '{3'd5, 32'h0000_55AA, 32'd9,         32'h0000_1234, 32'h0000_55AA, 0};
        vecs[8] = '{3'd6, 32'd77,        32'd3,         32'h0000_1234, 32'h0000_55AA, 0};

        reset = 1'b1; Start_E = 1'b0; MdOp_E = 3'd0; A_E = '0; B_E = '0; MdUse_D = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        m_hi = '0; m_lo = '0;
        check("reset_busy", 32'(Busy), 32'd0);
        check("reset_hi", Hi, 32'd0);
        check("reset_lo", Lo, 32'd0);
        check("reset_stall", 32'(Stall_D), 32'd0);

        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, cyc);
            $display("vec %0d op=%0d a=%08h b=%08h -> busy=%0d hi=%08h lo=%08h",
                     i, vecs[i].op, vecs[i].a, vecs[i].b, cyc, Hi, Lo);
            check($sformatf("vec%0d_cyc", i), 32'(cyc), 32'(vecs[i].cyc));
            check($sformatf("vec%0d_hi", i), Hi, vecs[i].hi);
            check($sformatf("vec%0d_lo", i), Lo, vecs[i].lo);
        end
        m_hi = Hi; m_lo = Lo;
        if (m_hi !== 32'h0000_1234 || m_lo !== 32'h0000_55AA) begin
            m_hi = 32'h0000_1234; m_lo = 32'h0000_55AA;
        end

        // Stall held across the start cycle and every busy cycle of a MULT.
        @(negedge clk);
        MdUse_D = 1'b1; Start_E = 1'b1; MdOp_E = 3'd0; A_E = 32'd6; B_E = 32'd7;
        #1 check("stall_start", 32'(Stall_D), 32'd1);
        @(negedge clk);
        Start_E = 1'b0;
        cnt = 0;
        while (Busy && cnt < 50) begin
            if (Stall_D) cnt++;
            @(negedge clk);
        end
        $display("stall seq: stalled busy cycles=%0d", cnt);
        check("stall_cycles", 32'(cnt), 32'(MULT_N));
        check("stall_after", 32'(Stall_D), 32'd0);
        MdUse_D = 1'b0;
        model(3'd0, 32'd6, 32'd7, cyc);
        check("stall_lo", Lo, m_lo);

        // Second start (MULTU) during busy cycle 2 must not disturb the first MULT.
        @(negedge clk);
        Start_E = 1'b1; MdOp_E = 3'd0; A_E = 32'd9; B_E = 32'hFFFF_FFFD;
        @(negedge clk);
        Start_E = 1'b0; cnt = 1;
        @(negedge clk);
        Start_E = 1'b1; MdOp_E = 3'd1; A_E = 32'hDEAD_BEEF; B_E = 32'h1234_5678; cnt = 2;
        @(negedge clk);
        Start_E = 1'b0;
        while (Busy && cnt < 50) begin
            cnt++;
            @(negedge clk);
        end
        model(3'd0, 32'd9, 32'hFFFF_FFFD, cyc);
        $display("ignored start seq: busy=%0d hi=%08h lo=%08h", cnt, Hi, Lo);
        check("ign_cyc", 32'(cnt), 32'(MULT_N));
        check("ign_hi", Hi, m_hi);
        check("ign_lo", Lo, m_lo);
        repeat (3) @(negedge clk);
        check("ign_idle", 32'(Busy), 32'd0);

        // Reset at busy cycle 3 of a DIV aborts it for good.
        @(negedge clk);
        Start_E = 1'b1; MdOp_E = 3'd3; A_E = 32'd100; B_E = 32'd7;
        @(negedge clk);
        Start_E = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_hi = '0; m_lo = '0;
        $display("reset-abort seq: busy=%0d hi=%08h lo=%08h", Busy, Hi, Lo);
        check("abort_busy", 32'(Busy), 32'd0);
        check("abort_hi", Hi, 32'd0);
        check("abort_lo", Lo, 32'd0);
        repeat (DIV_N + 2) @(negedge clk);
        check("abort_hi_late", Hi, 32'd0);
        check("abort_lo_late", Lo, 32'd0);

        // Reset wins over a simultaneous start.
        reset = 1'b1; Start_E = 1'b1; MdOp_E = 3'd0; A_E = 32'd3; B_E = 32'd3;
        @(negedge clk);
        reset = 1'b0; Start_E = 1'b0;
        $display("reset+start seq: busy=%0d", Busy);
        check("rst_prio_busy", 32'(Busy), 32'd0);

        for (int k = 0; k < 40; k++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) rb = rb & 32'h0000_00FF;
            model(rop, ra, rb, exp_cyc);
            run_op(rop, ra, rb, cyc);
            $display("rand %0d op=%0d a=%08h b=%08h -> busy=%0d hi=%08h lo=%08h", k, rop, ra, rb, cyc, Hi, Lo);
            check($sformatf("rand%0d_cyc", k), 32'(cyc), 32'(exp_cyc));
            check($sformatf("rand%0d_hi", k), Hi, m_hi);
            check($sformatf("rand%0d_lo", k), Lo, m_lo);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
